result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter `width`, default 20: the bit width of the result entering from the upstream adder stage.
REQ-002 SHALL have parameter `depth`, default 4: the number of FIFO entries; it SHALL be a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream adder's result/flag are valid this cycle.
REQ-006 SHALL have port in_result, input, `width` bits: the result from the adder stage.
REQ-007 SHALL have port in_flag, input, 1 bit: the flag from the adder stage.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear of the accumulator and the overflow indication; FIFO contents are untouched.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the head entry.
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port out_result, output, `width` bits: the result field of the head entry.
REQ-012 SHALL have port out_flag, output, 1 bit: the flag field of the head entry.
REQ-013 SHALL have port count, output, log2(`depth`)+1 bits: the number of stored entries.
REQ-014 SHALL have port full, output, 1 bit: count == `depth`.
REQ-015 SHALL have port empty, output, 1 bit: count == 0.
REQ-016 SHALL have port overflow, output, 1 bit: sticky; an input was dropped.
REQ-017 SHALL have port acc, output, `width`+4 bits: the running sum of accepted in_result values.

Function
REQ-018 pop SHALL equal out_valid AND out_ready; push SHALL equal in_valid AND (NOT full OR pop).
REQ-019 On push, the entry {in_flag, in_result} SHALL be written at the tail; it SHALL become visible at the head no earlier than the next cycle, with no same-cycle bypass.
REQ-020 out_valid, out_result and out_flag SHALL be driven directly from the head entry and the registered count, with no combinational path from in_* to out_*.
REQ-021 out_valid SHALL equal NOT empty; out_result and out_flag SHALL hold their last head value while empty, and no consumer may use them then.
REQ-022 Count update: push without pop SHALL increment count; pop without push SHALL decrement it; push with pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, a simultaneous pop and in_valid SHALL accept the new entry, with count staying at `depth`.
REQ-024 When full, in_valid without pop SHALL discard the input, set overflow to 1 on the next edge, and leave acc unchanged.
REQ-025 The read and write pointers SHALL wrap modulo `depth`; ordering SHALL be strictly first-in, first-out.
REQ-026 On every push, acc SHALL become acc + zero-extended in_result, modulo 2^(`width`+4).
REQ-027 A dropped input SHALL never be added to acc.
REQ-028 clr=1 SHALL set acc to 0 and overflow to 0 on the next edge.
REQ-029 If clr and push occur in the same cycle, acc SHALL become in_result.
REQ-030 If clr and a drop occur in the same cycle, overflow SHALL become 1 (the drop wins).
REQ-031 out_ready while empty SHALL have no effect.
REQ-032 count, full and empty SHALL be registered or derived only from registered state.

Reset
REQ-033 rstn=0 at a clock edge SHALL set count=0, both pointers=0, acc=0 and overflow=0, giving empty=1, full=0 and out_valid=0.
REQ-034 Reset SHALL take priority over every other input, including mid-operation while partly full or full; all pending entries SHALL be lost.
REQ-035 Storage array contents need no reset.
REQ-036 The first push after rstn returns high SHALL be accepted normally.

Verification
REQ-037 Single entry: push in_result=0x00005, in_flag=1, out_ready=0 -> next cycle out_valid=1, out_result=0x00005, out_flag=1, count=1, acc=0x0000005.
REQ-038 Fill and drop: 5 pushes of 1,2,3,4,5 with out_ready=0 -> full=1, count=4, overflow=1, acc=0x00000A; draining yields 1,2,3,4 in that order, then empty=1.
REQ-039 Full with simultaneous traffic: full with head=1, in_valid with 0x00009 and out_ready=1 -> count stays 4, overflow stays 0, new head=2, and 0x00009 emerges last.
REQ-040 Accumulator wrap: 17 pushes of 0xFFFFF with the FIFO drained continuously -> acc=(17*0xFFFFF) mod 2^24 = 0x0FFFEF, overflow=0.
REQ-041 Clear with push: acc=0x000100, clr=1 together with a push of 0x00007 -> acc=0x000007; clr alone -> acc=0, overflow=0.
REQ-042 Reset mid-operation: count=3, overflow=1, rstn=0 for one cycle -> count=0, empty=1, out_valid=0, acc=0, overflow=0; then a push of 0x00002 -> out_result=0x00002 the following cycle.

Source files
------------

// File: rtl/result_buffer.sv
// Result buffer behind the adder stage. This is a small FIFO of {flag, result} entries
// with a running sum of the accepted results and a sticky drop (overflow) indication.
module result_buffer #(
    parameter int width = 20,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [width-1:0]         in_result,
    input  logic                     in_flag,
    input  logic                     clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [width-1:0]         out_result,
    output logic                     out_flag,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [width+3:0]         acc
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = depth[aw:0];

    logic [width:0]   mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;
    logic [width+3:0] in_ext;

    assign full   = (count == full_cnt);
    assign empty  = (count == '0);
    assign pop    = out_valid & out_ready;
    assign push   = in_valid & (~full | pop);
    assign drop   = in_valid & ~push;
    assign in_ext = {4'b0000, in_result};

    // Head comes only from storage and registered state, so nothing bypasses from in_* to out_*.
    assign out_valid  = ~empty;
    assign out_result = mem[rd_ptr][width-1:0];
    assign out_flag   = mem[rd_ptr][width];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_flag, in_result};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (aw+1)'(1);
                2'b01:   count <= count - (aw+1)'(1);
                default: count <= count;
            endcase

            if (clr) begin
                acc <= push ? in_ext : '0;
            end else if (push) begin
                acc <= acc + in_ext;
            end

            // A drop in the same cycle as clr still leaves the sticky flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer. It combines directed scenarios with random traffic.
// The reference model is a queue of entries plus an integer accumulator.
module tb_result_buffer;

    localparam int WIDTH = 20;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic [WIDTH-1:0]  in_result;
    logic              in_flag;
    logic              clr;
    logic              out_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_result;
    logic              out_flag;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [WIDTH+3:0]  acc;

    result_buffer #(.width(WIDTH), .depth(DEPTH)) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_result(in_result),
        .in_flag(in_flag),
        .clr(clr),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_result(out_result),
        .out_flag(out_flag),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .acc(acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH:0]   mq[$];
    logic [WIDTH+3:0] m_acc;
    bit               m_ovf;
    int               vectors;
    int               miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("acc", 32'(acc), 32'(m_acc));
        if (mq.size() > 0) begin
            check("head_result", 32'(out_result), 32'(mq[0][WIDTH-1:0]));
            check("head_flag", 32'(out_flag), 32'(mq[0][WIDTH]));
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] r, input bit f,
                         input bit c, input bit rdy, input bit rn);
        bit m_pop;
        bit m_push;
        bit m_drop;
        rstn      = rn;
        in_valid  = v;
        in_result = r;
        in_flag   = f;
        clr       = c;
        out_ready = rdy;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_acc = '0;
            m_ovf = 1'b0;
        end else begin
            m_pop  = (mq.size() > 0) && rdy;
            m_push = v && ((mq.size() < DEPTH) || m_pop);
            m_drop = v && !m_push;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({f, r});
            if (c) m_acc = m_push ? {4'b0000, r} : '0;
            else if (m_push) m_acc = m_acc + {4'b0000, r};
            if (m_drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cycle(0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_acc       = '0;
        m_ovf       = 1'b0;
        rstn = 0; in_valid = 0; in_result = '0; in_flag = 0; clr = 0; out_ready = 0;

        do_reset();
        do_reset();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);

        // Single entry
        cycle(1, 20'h00005, 1, 0, 0, 1);
        check("single_result", 32'(out_result), 32'h5);
        check("single_flag", 32'(out_flag), 32'd1);
        check("single_count", 32'(count), 32'd1);
        check("single_acc", 32'(acc), 32'h5);

        // Fill and drop
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1, WIDTH'(i), 0, 0, 0, 1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf", 32'(overflow), 32'd1);
        check("fill_acc", 32'(acc), 32'hA);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(out_result), 32'(i));
            cycle(0, '0, 0, 0, 1, 1);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 0, 0, 0, 1);
        cycle(1, 20'h00009, 0, 0, 1, 1);
        check("thru_count", 32'(count), 32'd4);
        check("thru_ovf", 32'(overflow), 32'd0);
        check("thru_head", 32'(out_result), 32'd2);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1, 1);
        check("thru_last", 32'(out_result), 32'h9);
        cycle(0, '0, 0, 0, 1, 1);

        // Accumulator wrap
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1, 20'hFFFFF, 0, 0, 1, 1);
        check("wrap_acc", 32'(acc), 32'h0FFFEF);
        check("wrap_ovf", 32'(overflow), 32'd0);

        // Clear with push, then clear alone
        do_reset();
        cycle(1, 20'h00100, 0, 0, 1, 1);
        check("clr_pre", 32'(acc), 32'h100);
        cycle(1, 20'h00007, 0, 1, 1, 1);
        check("clr_push_acc", 32'(acc), 32'h7);
        cycle(0, '0, 0, 1, 1, 1);
        check("clr_acc", 32'(acc), 32'h0);
        check("clr_ovf", 32'(overflow), 32'd0);

        // Clear and drop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, WIDTH'(i + 3), 0, 0, 0, 1);
        cycle(1, 20'h00055, 0, 1, 0, 1);
        check("clr_drop_ovf", 32'(overflow), 32'd1);
        check("clr_drop_acc", 32'(acc), 32'h0);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, WIDTH'(i + 1), 0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1, 1);
        check("mid_count", 32'(count), 32'd3);
        check("mid_ovf", 32'(overflow), 32'd1);
        do_reset();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        cycle(1, 20'h00002, 0, 0, 0, 1);
        check("mid_first_push", 32'(out_result), 32'h2);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [WIDTH-1:0] r;
            r = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : WIDTH'($urandom);
            cycle($urandom_range(0, 3) != 0, r, 1'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 63) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
